// File: rtl/clk_mon_pkg.sv
// Shared definitions for the divided-clock monitor.
//   DEF_CNT_W   : default width of the period/high/low counters
//   mon_state_t : measurement FSM state encoding
//   sat_max()   : all-ones saturation value for a counter of a given width
package clk_mon_pkg;

  localparam int DEF_CNT_W = 8;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_RISE = 2'd1,
    MEAS_HIGH = 2'd2,
    MEAS_LOW  = 2'd3
  } mon_state_t;

  function automatic logic [31:0] sat_max(input int unsigned width);
    return (width >= 32) ? 32'hFFFF_FFFF : ((32'd1 << width) - 32'd1);
  endfunction

endpackage

// File: rtl/sync_edge_det.sv
// Multi-flop synchronizer for an asynchronous level, followed by one
// edge-detect flop. Reusable for any async input sampled in clk_in.
// Ports:
//   clk_in   : sampling clock
//   rst      : asynchronous active-high reset (all flops to 0)
//   async_in : asynchronous input level
//   rise     : synchronized 0->1 transition, one clk_in cycle wide
//   fall     : synchronized 1->0 transition, one clk_in cycle wide
module sync_edge_det #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk_in,
  input  logic rst,
  input  logic async_in,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_ff;
  logic                   sync_q;
  logic                   sync_q_d;

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      sync_ff  <= '0;
      sync_q_d <= 1'b0;
    end else begin
      sync_ff  <= {sync_ff[SYNC_STAGES-2:0], async_in};
      sync_q_d <= sync_q;
    end
  end

  // Synchronized level vs. its one-cycle-delayed copy
  assign sync_q = sync_ff[SYNC_STAGES-1];
  assign rise   = sync_q & ~sync_q_d;
  assign fall   = ~sync_q & sync_q_d;

endmodule

// File: rtl/clk_div_monitor.sv
// Divided-clock monitor: samples div_clk as data in the clk_in domain,
// measures its high time, low time and period in clk_in cycles, compares
// each period with expected_n and asserts locked after LOCK_COUNT
// consecutive good periods.
// Optional feature macro: DUTY_CHECK_EN -- when defined, a good period also
// requires |high_cnt - low_cnt| <= 1; otherwise only the period is checked.
// Ports:
//   clk_in     : reference clock (divider source clock)
//   rst        : asynchronous active-high reset
//   div_clk    : divided clock under test (asynchronous level)
//   meas_en    : measurement enable; low returns to IDLE
//   expected_n : expected divide ratio in clk_in cycles
//   period     : last completed period (saturates at all-ones)
//   high_cnt   : last measured high time
//   low_cnt    : last measured low time
//   meas_valid : one-cycle pulse when period/high_cnt/low_cnt update
//   locked     : LOCK_COUNT consecutive good periods seen
//   err        : one-cycle pulse on a bad period or a timeout
module clk_div_monitor
  import clk_mon_pkg::*;
#(
  parameter int CNT_W       = DEF_CNT_W,
  parameter int SYNC_STAGES = 2,
  parameter int LOCK_COUNT  = 4
) (
  input  logic             clk_in,
  input  logic             rst,
  input  logic             div_clk,
  input  logic             meas_en,
  input  logic [CNT_W-1:0] expected_n,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] high_cnt,
  output logic [CNT_W-1:0] low_cnt,
  output logic             meas_valid,
  output logic             locked,
  output logic             err
);

  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(sat_max(CNT_W));
  localparam logic [3:0]       LOCK_TGT = 4'(LOCK_COUNT);

  mon_state_t       state;
  logic [CNT_W-1:0] hcnt;
  logic [CNT_W-1:0] lcnt;
  logic [3:0]       good_cnt;
  logic             rise;
  logic             fall;
  logic [CNT_W:0]   sum_w;
  logic             sum_ovf;
  logic             duty_ok;
  logic             good;

  // Synchronizer + edge detect stage
  sync_edge_det #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk_in  (clk_in),
    .rst     (rst),
    .async_in(div_clk),
    .rise    (rise),
    .fall    (fall)
  );

  // Period evaluation (combinational, consumed at the publish cycle)
  assign sum_w   = {1'b0, hcnt} + {1'b0, lcnt};
  assign sum_ovf = sum_w[CNT_W];

`ifdef DUTY_CHECK_EN
  logic [CNT_W-1:0] duty_diff;
  assign duty_diff = (hcnt >= lcnt) ? (hcnt - lcnt) : (lcnt - hcnt);
  assign duty_ok   = (duty_diff <= CNT_W'(1));
`else
  assign duty_ok   = 1'b1;
`endif

  // An overflowed sum is bad even if the saturated value equals expected_n
  assign good = !sum_ovf && (sum_w[CNT_W-1:0] == expected_n) && duty_ok;

  // Measurement FSM and registered outputs
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      hcnt       <= '0;
      lcnt       <= '0;
      good_cnt   <= '0;
      period     <= '0;
      high_cnt   <= '0;
      low_cnt    <= '0;
      meas_valid <= 1'b0;
      locked     <= 1'b0;
      err        <= 1'b0;
    end else begin
      meas_valid <= 1'b0;
      err        <= 1'b0;
      if (!meas_en) begin
        // Abandon any in-flight measurement silently
        state    <= IDLE;
        good_cnt <= '0;
        locked   <= 1'b0;
      end else begin
        unique case (state)
          IDLE: begin
            state    <= WAIT_RISE;
            good_cnt <= '0;
            locked   <= 1'b0;
          end
          WAIT_RISE: begin
            // First rise marks the start of the first whole period
            if (rise) begin
              state <= MEAS_HIGH;
              hcnt  <= CNT_W'(1);
              lcnt  <= '0;
            end
          end
          MEAS_HIGH: begin
            if (fall) begin
              state <= MEAS_LOW;
              lcnt  <= CNT_W'(1);
            end else if (hcnt == CNT_MAX) begin
              state    <= WAIT_RISE;
              err      <= 1'b1;
              good_cnt <= '0;
              locked   <= 1'b0;
            end else begin
              hcnt <= hcnt + CNT_W'(1);
            end
          end
          MEAS_LOW: begin
            if (rise) begin
              high_cnt   <= hcnt;
              low_cnt    <= lcnt;
              period     <= sum_ovf ? CNT_MAX : sum_w[CNT_W-1:0];
              meas_valid <= 1'b1;
              state      <= MEAS_HIGH;
              hcnt       <= CNT_W'(1);
              lcnt       <= '0;
              if (good) begin
                if (good_cnt != LOCK_TGT) good_cnt <= good_cnt + 4'd1;
                locked <= (good_cnt >= (LOCK_TGT - 4'd1));
              end else begin
                err      <= 1'b1;
                good_cnt <= '0;
                locked   <= 1'b0;
              end
            end else if (lcnt == CNT_MAX) begin
              state    <= WAIT_RISE;
              err      <= 1'b1;
              good_cnt <= '0;
              locked   <= 1'b0;
            end else begin
              lcnt <= lcnt + CNT_W'(1);
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_clk_div_monitor.sv
`timescale 1ns/1ps
module tb_clk_div_monitor;
  import clk_mon_pkg::*;

  localparam int CNT_W = 8;

  logic             clk_in = 1'b0;
  logic             rst = 1'b1;
  logic             div_clk = 1'b0;
  logic             meas_en = 1'b0;
  logic [CNT_W-1:0] expected_n = '0;
  logic [CNT_W-1:0] period;
  logic [CNT_W-1:0] high_cnt;
  logic [CNT_W-1:0] low_cnt;
  logic             meas_valid;
  logic             locked;
  logic             err;

  int n_checks = 0;
  int n_fail   = 0;

  // Divider model: phases measured in clk_in half-cycles, edges placed 2 ns
  // after each clk_in edge so sampling never races the transition.
  int hi_h = 5;
  int lo_h = 5;
  bit div_run = 1'b0;
  int ph = 0;

  clk_div_monitor #(
    .CNT_W      (CNT_W),
    .SYNC_STAGES(2),
    .LOCK_COUNT (4)
  ) dut (
    .clk_in    (clk_in),
    .rst       (rst),
    .div_clk   (div_clk),
    .meas_en   (meas_en),
    .expected_n(expected_n),
    .period    (period),
    .high_cnt  (high_cnt),
    .low_cnt   (low_cnt),
    .meas_valid(meas_valid),
    .locked    (locked),
    .err       (err)
  );

  always #5 clk_in = ~clk_in;

  always @(clk_in) begin
    #2;
    if (!div_run) begin
      div_clk = 1'b0;
      ph = 0;
    end else begin
      ph++;
      if (div_clk) begin
        if (ph >= hi_h) begin div_clk = 1'b0; ph = 0; end
      end else if (ph >= lo_h) begin
        div_clk = 1'b1; ph = 0;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic wait_meas(input int bound, output bit got, output int cycles);
    got = 1'b0;
    cycles = 0;
    while (!got && cycles < bound) begin
      @(posedge clk_in); #1;
      cycles++;
      if (meas_valid) got = 1'b1;
      else if (err) begin
        n_checks++; n_fail++;
        $display("FAIL stray_err: err=1 without meas_valid at %0t", $time);
      end
    end
    if (!got) begin
      n_checks++; n_fail++;
      $display("FAIL meas_wait: no meas_valid within %0d cycles", bound);
    end
  endtask

  task automatic restart(input int h, input int l, input int n);
    meas_en = 1'b0;
    div_run = 1'b0;
    repeat (6) @(posedge clk_in);
    #1;
    hi_h = h;
    lo_h = l;
    expected_n = CNT_W'(n);
    div_run = 1'b1;
    meas_en = 1'b1;
  endtask

  // Collect 4 measurements of a good stream; locked must rise on the 4th.
  task automatic lock_seq(input string tag, input int exp_p);
    bit got;
    int cyc;
    for (int k = 0; k < 4; k++) begin
      wait_meas(100, got, cyc);
      if (got) begin
        check($sformatf("%s_period_%0d", tag, k), 32'(period), 32'(exp_p));
        check($sformatf("%s_err_%0d", tag, k), 32'(err), 32'd0);
        check($sformatf("%s_locked_%0d", tag, k), 32'(locked), 32'(k == 3));
      end
    end
  endtask

  typedef struct {
    int hi_h;
    int lo_h;
    int exp_n;
    int n_meas;
    int exp_period;
    int exp_min;
    bit good;
  } vec_t;

  vec_t vecs[5];

  initial begin
    bit got;
    int cyc;
    bit err_seen;
    bit mv_seen;
    bit in_low;
    int lo_v;
    int hi_v;

    vecs[0] = '{5, 5, 5, 6, 5, 2, 1'b1};   // N=5, right ratio
    vecs[1] = '{7, 7, 5, 5, 7, 3, 1'b0};   // N=7 against expected 5
    vecs[2] = '{3, 3, 3, 5, 3, 1, 1'b1};   // N=3
`ifdef DUTY_CHECK_EN
    vecs[3] = '{8, 2, 5, 5, 5, 1, 1'b0};   // high 4 / low 1, duty fails
`else
    vecs[3] = '{8, 2, 5, 5, 5, 1, 1'b1};   // high 4 / low 1, period only
`endif
    vecs[4] = '{9, 9, 9, 5, 9, 4, 1'b1};   // N=9

    // Reset state
    repeat (3) @(posedge clk_in);
    #1;
    check("reset_outputs", 32'({period, high_cnt, low_cnt, meas_valid, locked, err}), 32'd0);
    rst = 1'b0;

    // Table-driven vectors
    for (int v = 0; v < 5; v++) begin
      restart(vecs[v].hi_h, vecs[v].lo_h, vecs[v].exp_n);
      for (int k = 0; k < vecs[v].n_meas; k++) begin
        wait_meas(100, got, cyc);
        if (got) begin
          lo_v = (high_cnt < low_cnt) ? int'(high_cnt) : int'(low_cnt);
          hi_v = (high_cnt < low_cnt) ? int'(low_cnt) : int'(high_cnt);
          check($sformatf("v%0d_period_%0d", v, k), 32'(period), 32'(vecs[v].exp_period));
          check($sformatf("v%0d_min_%0d", v, k), 32'(lo_v), 32'(vecs[v].exp_min));
          check($sformatf("v%0d_max_%0d", v, k), 32'(hi_v),
                32'(vecs[v].exp_period - vecs[v].exp_min));
          check($sformatf("v%0d_err_%0d", v, k), 32'(err), 32'(!vecs[v].good));
          check($sformatf("v%0d_locked_%0d", v, k), 32'(locked),
                32'(vecs[v].good && k >= 3));
        end
      end
    end

    // Timeout: lock on N=5, then hold div_clk low
    restart(5, 5, 5);
    lock_seq("to_lock", 5);
    div_run = 1'b0;
    err_seen = 1'b0;
    mv_seen = 1'b0;
    cyc = 0;
    while (!err_seen && cyc < 400) begin
      @(posedge clk_in); #1;
      cyc++;
      if (meas_valid) mv_seen = 1'b1;
      if (err) err_seen = 1'b1;
    end
    check("timeout_err_seen", 32'(err_seen), 32'd1);
    check("timeout_latency_window", 32'(cyc >= 254 && cyc <= 260), 32'd1);
    check("timeout_no_meas_valid", 32'(mv_seen), 32'd0);
    check("timeout_locked_drop", 32'(locked), 32'd0);
    check("timeout_state", 32'(dut.state), 32'(WAIT_RISE));
    div_run = 1'b1;
    lock_seq("to_relock", 5);

    // meas_en dropped for one cycle during MEAS_LOW
    restart(3, 3, 3);
    lock_seq("en_lock", 3);
    in_low = 1'b0;
    cyc = 0;
    while (!in_low && cyc < 20) begin
      @(posedge clk_in); #1;
      cyc++;
      if (dut.state == MEAS_LOW) in_low = 1'b1;
    end
    check("en_reach_meas_low", 32'(in_low), 32'd1);
    meas_en = 1'b0;
    @(posedge clk_in); #1;
    check("en_abort_no_mv", 32'(meas_valid), 32'd0);
    check("en_abort_locked", 32'(locked), 32'd0);
    meas_en = 1'b1;
    wait_meas(100, got, cyc);
    check("en_partial_discarded", 32'(cyc >= 4), 32'd1);
    check("en_first_period", 32'(period), 32'd3);
    check("en_first_locked", 32'(locked), 32'd0);
    for (int k = 1; k < 4; k++) begin
      wait_meas(100, got, cyc);
      if (got) check($sformatf("en_relock_%0d", k), 32'(locked), 32'(k == 3));
    end

    // Asynchronous reset mid-MEAS_HIGH while locked
    check("ar_pre_locked", 32'(locked), 32'd1);
    #3;
    rst = 1'b1;
    #1;
    check("ar_outputs_cleared", 32'({period, high_cnt, low_cnt, meas_valid, locked, err}), 32'd0);
    @(posedge clk_in);
    #3;
    rst = 1'b0;
    wait_meas(100, got, cyc);
    check("ar_first_full_period", 32'(cyc >= 4), 32'd1);
    check("ar_period", 32'(period), 32'd3);
    check("ar_err", 32'(err), 32'd0);
    check("ar_locked", 32'(locked), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
